// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type, arbiter state encoding and round-robin pointer helper.
package noc_pkg;

    localparam int FLIT_WIDTH = 32;

    typedef logic [FLIT_WIDTH-1:0] flit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Index following idx in a ring of n entries.
    function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping to 0.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        // First pass covers ptr..N-1; the second pass only matters when that range is empty.
        for (int i = 0; i < N; i++) begin
            if (en && !found && req[i] && (i >= int'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (en && !found && req[i]) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/node_port_arbiter.sv
// Shares one node output port between N_REQ requesters, round-robin, relaying ack/rej
// back to the winner and forcing a reject when the downstream stays silent.
//
// state | meaning
// IDLE  | no owner; pick next requester at/after pointer
// SEND  | granted flit on out_flit, waiting for out_ack/out_rej/timeout/withdraw
// RESP  | one-cycle ack or rej pulse to the owner, pointer advances
module node_port_arbiter #(
    parameter int N_REQ      = 4,
    parameter int FLIT_WIDTH = noc_pkg::FLIT_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ*FLIT_WIDTH-1:0] in_flit,
    input  logic [N_REQ-1:0]            in_enable,
    output logic [N_REQ-1:0]            in_ack,
    output logic [N_REQ-1:0]            in_rej,
    output logic [FLIT_WIDTH-1:0]       out_flit,
    output logic                        out_enable,
    input  logic                        out_ack,
    input  logic                        out_rej,
    output logic [N_REQ-1:0]            grant,
    output logic                        busy
);

    import noc_pkg::*;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FLIT_WIDTH-1:0] flit_q, flit_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [N_REQ-1:0]      ack_q, ack_d;
    logic [N_REQ-1:0]      rej_q, rej_d;
    logic                  out_en_q, out_en_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             timed_out;
    logic             withdrawn;
    logic [IDX_W-1:0] ptr_after;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req (in_enable),
        .ptr (ptr_q),
        .en  (state_q == IDLE),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign withdrawn = ((in_enable & grant_q) == '0);
    assign ptr_after = IDX_W'(rr_next_idx(32'(idx_q), N_REQ));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        flit_d   = flit_q;
        grant_d  = grant_q;
        out_en_d = out_en_q;
        ack_d    = '0;
        rej_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (arb_gnt != '0) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (arb_gnt[i]) flit_d = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
                    end
                    idx_d    = arb_idx;
                    grant_d  = arb_gnt;
                    out_en_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                // A downstream answer (ack+rej counts as rej) outranks timeout and withdraw.
                if (out_ack || out_rej) begin
                    ack_d    = out_rej ? '0 : grant_q;
                    rej_d    = out_rej ? grant_q : '0;
                    out_en_d = 1'b0;
                    state_d  = RESP;
                end else if (timed_out) begin
                    rej_d    = grant_q;
                    out_en_d = 1'b0;
                    state_d  = RESP;
                end else if (withdrawn) begin
                    out_en_d = 1'b0;
                    grant_d  = '0;
                    ptr_d    = ptr_after;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                grant_d = '0;
                ptr_d   = ptr_after;
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                out_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            flit_q   <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            rej_q    <= '0;
            out_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            flit_q   <= flit_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            rej_q    <= rej_d;
            out_en_q <= out_en_d;
        end
    end

    assign in_ack     = ack_q;
    assign in_rej     = rej_q;
    assign out_flit   = flit_q;
    assign out_enable = out_en_q;
    assign grant      = grant_q;
    assign busy       = (state_q != IDLE);

endmodule
